// File: rtl/accel_sample_pkg.sv
// Shared constants and types for the timer-paced accelerometer sample buffer.
package accel_sample_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_LEVEL   = 3'd2;
  localparam logic [2:0] ADDR_THRESH  = 3'd3;
  localparam logic [2:0] ADDR_DATA    = 3'd4;

  localparam int ST_AVAIL = 0;
  localparam int ST_OVF   = 1;
  localparam int ST_MISS  = 2;
  localparam int ST_TMO   = 3;
  localparam int ST_BUSY  = 4;

  localparam int CTL_EN     = 0;
  localparam int CTL_IRQ_EN = 1;
  localparam int CTL_FLUSH  = 2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WX, S_WY, S_WZ} fsm_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } sample_t;

endpackage

// File: rtl/accel_word_fifo.sv
// Single-clock 16-bit word FIFO with occupancy/free outputs and a flush that beats push/pop.
module accel_word_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [15:0]            din,
  output logic [15:0]            dout,
  output logic [$clog2(DEPTH):0] level,
  output logic [$clog2(DEPTH):0] free
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop.
  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level != LW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];
  assign free    = LW'(DEPTH) - level;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/accel_sample_buffer.sv
// Tick-paced X/Y/Z capture into a word FIFO drained over an Avalon-MM slave, with
// threshold/error interrupt.
module accel_sample_buffer
  import accel_sample_pkg::*;
#(
  parameter int DEPTH          = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int THRESH_RESET   = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  output logic        sample_req,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  fsm_t          state;
  sample_t       smp;
  logic [TW-1:0] tmo_cnt;
  logic          ovf, miss, tmo, enable, irq_en;
  logic [LW-1:0] thresh, level, free;
  logic [15:0]   fifo_din, fifo_dout, rd_mux;
  logic          rd, wr, push, pop, flush;
  logic          unused_wdata;

  assign rd           = chipselect & ~read_n;
  assign wr           = chipselect & ~write_n;
  assign pop          = rd && (address == ADDR_DATA);
  assign flush        = wr && (address == ADDR_CONTROL) && writedata[CTL_FLUSH];
  assign push         = (state == S_WX) || (state == S_WY) || (state == S_WZ);
  assign unused_wdata = ^writedata;

  always_comb begin
    fifo_din = smp.x;
    case (state)
      S_WY:    fifo_din = smp.y;
      S_WZ:    fifo_din = smp.z;
      default: fifo_din = smp.x;
    endcase
  end

  accel_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .level (level),
    .free  (free)
  );

  // Sticky bits live here with the FSM so an error event can override a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sample_req <= 1'b0;
      tmo_cnt    <= '0;
      smp        <= '0;
      ovf        <= 1'b0;
      miss       <= 1'b0;
      tmo        <= 1'b0;
    end else begin
      if (wr && (address == ADDR_STATUS)) begin
        ovf  <= 1'b0;
        miss <= 1'b0;
        tmo  <= 1'b0;
      end
      if (tick && (state != S_IDLE)) miss <= 1'b1;
      case (state)
        S_IDLE: if (tick && enable) begin
          state      <= S_WAIT;
          sample_req <= 1'b1;
          tmo_cnt    <= '0;
        end
        S_WAIT: begin
          if (sample_valid) begin
            smp        <= '{x: sample_x, y: sample_y, z: sample_z};
            sample_req <= 1'b0;
            if (free >= LW'(3)) state <= S_WX;
            else begin
              ovf   <= 1'b1;
              state <= S_IDLE;
            end
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo        <= 1'b1;
            sample_req <= 1'b0;
            state      <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WX:    state <= S_WY;
        S_WY:    state <= S_WZ;
        S_WZ:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS: begin
        rd_mux[ST_AVAIL] = (level >= LW'(3));
        rd_mux[ST_OVF]   = ovf;
        rd_mux[ST_MISS]  = miss;
        rd_mux[ST_TMO]   = tmo;
        rd_mux[ST_BUSY]  = (state != S_IDLE);
      end
      ADDR_CONTROL: begin
        rd_mux[CTL_EN]     = enable;
        rd_mux[CTL_IRQ_EN] = irq_en;
      end
      ADDR_LEVEL:  rd_mux = 16'(level);
      ADDR_THRESH: rd_mux = 16'(thresh);
      ADDR_DATA:   rd_mux = (level != '0) ? fifo_dout : 16'h0000;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      thresh   <= LW'(THRESH_RESET);
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr && (address == ADDR_CONTROL)) begin
        enable <= writedata[CTL_EN];
        irq_en <= writedata[CTL_IRQ_EN];
      end
      if (wr && (address == ADDR_THRESH)) thresh <= writedata[LW-1:0];
      if (rd) readdata <= rd_mux;
      // THRESH = 0 disables the level term; errors still fire.
      irq <= irq_en && (((thresh != '0) && (level >= thresh)) || ovf || miss || tmo);
    end
  end

endmodule

// File: tb/tb_accel_sample_buffer.sv
// Directed bench for accel_sample_buffer: register table plus capture/error/flush/reset sequences.
module tb_accel_sample_buffer;
  import accel_sample_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        sample_req;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  accel_sample_buffer #(.DEPTH(64), .TIMEOUT_CYCLES(1024), .THRESH_RESET(24)) dut (
    .clk(clk), .reset(reset), .tick(tick), .sample_req(sample_req),
    .sample_valid(sample_valid), .sample_x(sample_x), .sample_y(sample_y),
    .sample_z(sample_z), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    cyc(1);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    tick = 1'b0; sample_valid = 1'b0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  // Full request/response exchange; leaves the FSM back in IDLE with irq settled.
  task automatic do_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    check("req_rise", sample_req, 1);
    cyc(2);
    sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
    cyc(1);
    sample_valid = 1'b0;
    cyc(4);
  endtask

  initial begin
    int n;
    cyc(2);
    reset = 1'b0;

    check("rst_req", sample_req, 0);
    check("rst_irq", irq, 0);
    check("rst_readdata", readdata, 0);

    vecs[0]  = '{1'b0, ADDR_STATUS,  16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, ADDR_CONTROL, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, ADDR_LEVEL,   16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, ADDR_THRESH,  16'h0000, 16'd24};
    vecs[4]  = '{1'b0, ADDR_DATA,    16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 3'd5,         16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 3'd7,         16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, ADDR_CONTROL, 16'h0003, 16'h0000};
    vecs[8]  = '{1'b0, ADDR_CONTROL, 16'h0000, 16'h0003};
    vecs[9]  = '{1'b1, ADDR_CONTROL, 16'h0007, 16'h0000};
    vecs[10] = '{1'b0, ADDR_CONTROL, 16'h0000, 16'h0003};
    vecs[11] = '{1'b1, ADDR_THRESH,  16'hFFFF, 16'h0000};
    vecs[12] = '{1'b0, ADDR_THRESH,  16'h0000, 16'h007F};
    vecs[13] = '{1'b1, ADDR_THRESH,  16'h0000, 16'h0000};
    vecs[14] = '{1'b0, ADDR_THRESH,  16'h0000, 16'h0000};
    vecs[15] = '{1'b1, ADDR_DATA,    16'h1234, 16'h0000};
    vecs[16] = '{1'b0, ADDR_LEVEL,   16'h0000, 16'h0000};
    vecs[17] = '{1'b1, ADDR_STATUS,  16'hFFFF, 16'h0000};
    vecs[18] = '{1'b0, ADDR_STATUS,  16'h0000, 16'h0000};

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      else rd_check($sformatf("vec%0d_a%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end
    cyc(2);
    check("irq_thresh0_empty", irq, 0);

    // basic capture with boundary on push latency
    do_reset();
    bus_write(ADDR_CONTROL, 16'h0001);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    check("basic_req_rise", sample_req, 1);
    cyc(5);
    sample_x = 16'h0123; sample_y = 16'hFEDC; sample_z = 16'h7FFF; sample_valid = 1'b1;
    cyc(1);
    sample_valid = 1'b0;
    check("basic_req_fall", sample_req, 0);
    cyc(2);
    rd_check("basic_level_before_z", ADDR_LEVEL, 16'd2);
    rd_check("basic_level", ADDR_LEVEL, 16'd3);
    rd_check("basic_status", ADDR_STATUS, 16'h0001);
    rd_check("basic_x", ADDR_DATA, 16'h0123);
    rd_check("basic_y", ADDR_DATA, 16'hFEDC);
    rd_check("basic_z", ADDR_DATA, 16'h7FFF);
    rd_check("basic_level_empty", ADDR_LEVEL, 16'd0);
    rd_check("empty_data_read", ADDR_DATA, 16'h0000);
    rd_check("empty_level_after", ADDR_LEVEL, 16'd0);

    // timeout
    do_reset();
    bus_write(ADDR_CONTROL, 16'h0003);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    check("tmo_req_rise", sample_req, 1);
    n = 0;
    while (sample_req && n < 1100) begin
      cyc(1);
      n++;
    end
    check("tmo_req_len", n, 1024);
    rd_check("tmo_status", ADDR_STATUS, 16'h0008);
    check("tmo_irq", irq, 1);
    bus_write(ADDR_STATUS, 16'h0000);
    cyc(1);
    check("tmo_irq_clear", irq, 0);
    rd_check("tmo_status_clear", ADDR_STATUS, 16'h0000);

    // overflow
    do_reset();
    bus_write(ADDR_CONTROL, 16'h0001);
    for (int i = 0; i < 21; i++)
      do_sample(16'(3 * i), 16'(3 * i + 1), 16'(3 * i + 2));
    rd_check("ovf_level63", ADDR_LEVEL, 16'd63);
    do_sample(16'hAAAA, 16'hBBBB, 16'hCCCC);
    rd_check("ovf_status", ADDR_STATUS, 16'h0003);
    rd_check("ovf_level_kept", ADDR_LEVEL, 16'd63);
    rd_check("ovf_pop0", ADDR_DATA, 16'd0);
    do_sample(16'hAAAA, 16'hBBBB, 16'hCCCC);
    rd_check("ovf_free2_drop", ADDR_LEVEL, 16'd62);
    rd_check("ovf_pop1", ADDR_DATA, 16'd1);
    do_sample(16'hAAAA, 16'hBBBB, 16'hCCCC);
    rd_check("ovf_full", ADDR_LEVEL, 16'd64);

    // missed tick
    do_reset();
    bus_write(ADDR_CONTROL, 16'h0001);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    check("miss_req_held", sample_req, 1);
    sample_x = 16'h1111; sample_y = 16'h2222; sample_z = 16'h3333; sample_valid = 1'b1;
    cyc(1);
    sample_valid = 1'b0;
    cyc(4);
    check("miss_no_second_req", sample_req, 0);
    rd_check("miss_status", ADDR_STATUS, 16'h0005);
    rd_check("miss_level", ADDR_LEVEL, 16'd3);

    // threshold irq
    do_reset();
    bus_write(ADDR_THRESH, 16'd6);
    bus_write(ADDR_CONTROL, 16'h0003);
    do_sample(16'h0001, 16'h0002, 16'h0003);
    check("thr_irq_3", irq, 0);
    do_sample(16'h0004, 16'h0005, 16'h0006);
    check("thr_irq_6", irq, 1);
    rd_check("thr_pop", ADDR_DATA, 16'h0001);
    cyc(1);
    check("thr_irq_5", irq, 0);

    // flush while Y is being pushed
    do_reset();
    bus_write(ADDR_CONTROL, 16'h0001);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    sample_x = 16'h0AAA; sample_y = 16'h0BBB; sample_z = 16'h0CCC; sample_valid = 1'b1;
    cyc(1);
    sample_valid = 1'b0;
    cyc(1);
    bus_write(ADDR_CONTROL, 16'h0005);
    cyc(1);
    rd_check("flush_level", ADDR_LEVEL, 16'd1);
    rd_check("flush_z_kept", ADDR_DATA, 16'h0CCC);

    // reset while waiting for the front-end
    do_reset();
    bus_write(ADDR_THRESH, 16'd10);
    bus_write(ADDR_CONTROL, 16'h0003);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
    check("rstw_irq_pre", irq, 1);
    reset = 1'b1;
    cyc(1);
    check("rstw_req", sample_req, 0);
    check("rstw_irq", irq, 0);
    reset = 1'b0;
    rd_check("rstw_status", ADDR_STATUS, 16'h0000);
    rd_check("rstw_thresh", ADDR_THRESH, 16'd24);
    rd_check("rstw_control", ADDR_CONTROL, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
